// File: rtl/aha_reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, a width helper
// and an elaboration-time parameter legality check.
`ifndef AHA_RESET_SEQUENCER_PKG_SV
`define AHA_RESET_SEQUENCER_PKG_SV

`define AHA_RSQ_CHECK_PARAMS(N, H, G) \
  if ((N) < 1 || (N) > 32 || (H) < 1 || (G) < 1) begin : g_bad_params \
    $error("aha_reset_sequencer: illegal N_DOMAINS/HOLD_CYCLES/GAP_CYCLES"); \
  end

package aha_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Ceiling log2; callers always pass value >= 2 so the result is never zero.
  function automatic int clog2(input int value);
    for (int w = 0; w < 32; w++) begin
      if ((1 << w) >= value) return w;
    end
    return 32;
  endfunction

endpackage

`endif

// File: rtl/aha_reset_seq_timer.sv
// Clearable up-counter with a combinational terminal-count compare against LIMIT.
module aha_reset_seq_timer #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic [WIDTH-1:0] LIMIT,
  output logic             TC
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign TC = (count_q == LIMIT);

endmodule

// File: rtl/aha_reset_sequencer.sv
// Sequences per-domain active-low resets: assert all, hold, then release in index
// order with a fixed gap; software can request a full re-sequence via SW_REQ/SW_ACK.
module aha_reset_sequencer
  import aha_reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SW_REQ,
  output logic                 SW_ACK,
  output logic [N_DOMAINS-1:0] DOMAIN_RSTn,
  output logic                 READY,
  output logic                 BUSY
);

  `AHA_RSQ_CHECK_PARAMS(N_DOMAINS, HOLD_CYCLES, GAP_CYCLES)

  localparam int TMR_W = clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1);
  localparam int IDX_W = clog2(N_DOMAINS + 1);
  localparam logic [TMR_W-1:0] HOLD_LIM = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LIM  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] rstn_q, rstn_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 tmr_clr, tmr_tc;
  logic [TMR_W-1:0]     tmr_limit;

  aha_reset_seq_timer #(.WIDTH(TMR_W)) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (tmr_clr),
    .LIMIT (tmr_limit),
    .TC    (tmr_tc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    rstn_d    = rstn_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    ack_d     = ack_q & SW_REQ;
    tmr_clr   = 1'b0;
    tmr_limit = (state_q == ST_ASSERT) ? HOLD_LIM : GAP_LIM;

    unique case (state_q)
      ST_ASSERT: begin
        if (tmr_tc) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
          tmr_clr = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          for (int k = 0; k < N_DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) rstn_d[k] = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        // Timer held at zero here so an accept starts the hold from a clean count.
        tmr_clr = 1'b1;
        if (SW_REQ && !ack_q) begin
          ack_d   = 1'b1;
          rstn_d  = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_ASSERT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign DOMAIN_RSTn = rstn_q;
  assign READY       = ready_q;
  assign BUSY        = busy_q;
  assign SW_ACK      = ack_q;

endmodule

// File: tb/tb_aha_reset_sequencer.sv
// Self-checking bench: directed vector table, N=1 corner case, then randomized
// SW_REQ/RESET traffic compared every cycle against an edge-count reference model.
module tb_aha_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       req;
  logic       req1;
  logic       ack, ready, busy;
  logic [3:0] rstn;
  logic       ack1, ready1, busy1;
  logic [0:0] rstn1;

  int n_vec = 0;
  int n_bad = 0;

  aha_reset_sequencer dut (
    .CLK         (clk),
    .RESET       (rst),
    .SW_REQ      (req),
    .SW_ACK      (ack),
    .DOMAIN_RSTn (rstn),
    .READY       (ready),
    .BUSY        (busy)
  );

  aha_reset_sequencer #(.N_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .CLK         (clk),
    .RESET       (rst),
    .SW_REQ      (req1),
    .SW_ACK      (ack1),
    .DOMAIN_RSTn (rstn1),
    .READY       (ready1),
    .BUSY        (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: e = edges since the sequence started (reset or accept edge = 0).
  typedef struct {
    int   e;
    logic ack;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_next(mdl_t m, logic r, logic q, int n, int h, int g);
    mdl_t nx;
    if (r) begin
      nx.e   = 0;
      nx.ack = 1'b0;
    end else if (m.e >= h + n * g && q && !m.ack) begin
      nx.e   = 0;
      nx.ack = 1'b1;
    end else begin
      nx.e   = (m.e < 100000) ? m.e + 1 : m.e;
      nx.ack = m.ack & q;
    end
    return nx;
  endfunction

  function automatic logic [31:0] exp_rstn(int e, int n, int h, int g);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = (e >= h + (k + 1) * g);
    return r;
  endfunction

  function automatic logic exp_ready(int e, int n, int h, int g);
    return (e >= h + n * g);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] r0, r1;
    @(posedge clk);
    m0 = mdl_next(m0, rst, req, 4, 16, 4);
    m1 = mdl_next(m1, rst, req1, 1, 1, 1);
    @(negedge clk);
    r0 = 32'(rstn);
    r1 = 32'(rstn1);
    check("mdl_rstn",   r0, exp_rstn(m0.e, 4, 16, 4));
    check("mdl_ready",  32'(ready), 32'(exp_ready(m0.e, 4, 16, 4)));
    check("mdl_busy",   32'(busy), 32'(!exp_ready(m0.e, 4, 16, 4)));
    check("mdl_ack",    32'(ack), 32'(m0.ack));
    check("order",      r0 & (r0 + 32'd1), 32'd0);
    check("mdl1_rstn",  r1, exp_rstn(m1.e, 1, 1, 1));
    check("mdl1_ready", 32'(ready1), 32'(exp_ready(m1.e, 1, 1, 1)));
    check("mdl1_busy",  32'(busy1), 32'(!exp_ready(m1.e, 1, 1, 1)));
    check("mdl1_ack",   32'(ack1), 32'(m1.ack));
  endtask

  typedef struct {
    int         cycles;
    logic       rst;
    logic       req;
    logic [3:0] rstn;
    logic       ready;
    logic       busy;
    logic       ack;
  } vec_t;

  vec_t vecs[$];
  int   run_len;

  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    req1 = 1'b0;
    m0   = '{e: 0, ack: 1'b0};
    m1   = '{e: 0, ack: 1'b0};

    // {cycles, rst, req, expected rstn, ready, busy, ack} after the last edge of the row
    vecs.push_back('{3,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{19, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3,  1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4,  1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3,  1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2,  1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{4,  1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{14, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4,  1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4,  1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4,  1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{9,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{22, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{32, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{5,  1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{25, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{19, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_rstn", i),  32'(rstn),  32'(vecs[i].rstn));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
      check($sformatf("vec%0d_ack", i),   32'(ack),   32'(vecs[i].ack));
    end

    // Degenerate instance: single domain, one-cycle hold and gap.
    rst = 1'b1;
    req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("n1_edge1_rstn",  32'(rstn1),  32'd0);
    check("n1_edge1_ready", 32'(ready1), 32'd0);
    tick();
    check("n1_edge2_rstn",  32'(rstn1),  32'd1);
    check("n1_edge2_ready", 32'(ready1), 32'd1);
    check("n1_edge2_busy",  32'(busy1),  32'd0);

    // Randomized handshake and reset traffic against the model.
    run_len = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (run_len == 0) begin
        req     = 1'($urandom_range(0, 1));
        run_len = $urandom_range(1, 45);
      end
      run_len--;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
